pe_operand_join: RTL and testbench



---
 rtl/pe_pkg.sv | 26 ++
 rtl/pe_operand_fifo.sv | 74 +++++++
 rtl/pe_operand_join.sv | 136 +++++++++++++
 tb/tb_pe_operand_join.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the PE operand join stage.
//   DEFAULT_DATA_WIDTH : default operand width
//   NUM_OPERANDS       : number of operand streams feeding the ALU
//   FIRE_CNT_W         : width of the issued-bundle counter
//   op_mask_t          : one bit per operand, bit i selects operand i+1
//   out_state_t        : output bundle register state
package pe_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int NUM_OPERANDS       = 3;
  localparam int FIRE_CNT_W         = 16;

  typedef logic [NUM_OPERANDS-1:0] op_mask_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // True when every operand selected by the mask has data waiting.
  // An empty mask never counts as ready.
  function automatic logic join_ready(input op_mask_t mask, input op_mask_t empty);
    return (mask != '0) && ((mask & empty) == '0);
  endfunction

endpackage

// File: rtl/pe_operand_fifo.sv
// pe_operand_fifo: small first-word-fall-through FIFO for one operand stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, data : write request and write data (ignored when full)
//   pop        : read request (ignored when empty)
//   full/empty : status flags derived from the occupancy counter
//   head       : oldest entry, valid whenever empty is low
//   count      : occupancy, 0..DEPTH
module pe_operand_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Full is checked against the pre-pop occupancy, so a full FIFO never
  // takes a write in the same cycle it is read.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is read asynchronously so an operand written at one edge can
  // join at the very next edge; with a handful of entries this maps onto
  // distributed memory rather than block RAM.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pe_operand_join.sv
// pe_operand_join: buffers three operand streams and joins the ones selected
// by cfg_op_mask into a registered bundle for the PE ALU.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cfg_op_mask                 : static operand select, bit i -> operand i+1
//   inN_data/inN_valid/inN_ready: operand N input stream (valid/ready)
//   data_in1..data_in3          : registered operands to the ALU
//   op_valid / op_ready         : bundle handshake towards the result sampler
//   fire_cnt                    : number of bundles issued, wraps at 2^16
module pe_operand_join
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            cfg_op_mask,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [DATA_WIDTH-1:0] in2_data,
  input  logic                  in2_valid,
  output logic                  in2_ready,
  input  logic [DATA_WIDTH-1:0] in3_data,
  input  logic                  in3_valid,
  output logic                  in3_ready,
  output logic [DATA_WIDTH-1:0] data_in1,
  output logic [DATA_WIDTH-1:0] data_in2,
  output logic [DATA_WIDTH-1:0] data_in3,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [15:0]           fire_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  op_mask_t              mask;
  op_mask_t              valid_vec;
  op_mask_t              ready_vec;
  op_mask_t              full_vec;
  op_mask_t              empty_vec;
  logic [DATA_WIDTH-1:0] in_data   [NUM_OPERANDS];
  logic [DATA_WIDTH-1:0] head_data [NUM_OPERANDS];
  logic [DATA_WIDTH-1:0] data_reg  [NUM_OPERANDS];
  logic [CNT_W-1:0]      occupancy [NUM_OPERANDS];
  logic [FIRE_CNT_W-1:0] fire_cnt_reg;
  out_state_t            state_reg;
  out_state_t            state_next;
  logic                  fire;
  logic                  unused_occupancy;

  assign mask      = cfg_op_mask;
  assign valid_vec = {in3_valid, in2_valid, in1_valid};
  assign in_data[0] = in1_data;
  assign in_data[1] = in2_data;
  assign in_data[2] = in3_data;

  assign in1_ready = ready_vec[0];
  assign in2_ready = ready_vec[1];
  assign in3_ready = ready_vec[2];

  assign op_valid = (state_reg == OUT_FULL);

  // A new bundle may be loaded when the output slot is free or is being
  // consumed this very cycle.
  assign fire = join_ready(mask, empty_vec) && (!op_valid || op_ready);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPERANDS; gi++) begin : g_operand
      // Ready is gated by rst_n so it drops as soon as reset is asserted,
      // not only once the FIFO flags have been cleared.
      assign ready_vec[gi] = rst_n && mask[gi] && !full_vec[gi];

      pe_operand_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .CNT_W     (CNT_W)
      ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (valid_vec[gi] && ready_vec[gi]),
        .data (in_data[gi]),
        .pop  (fire && mask[gi]),
        .full (full_vec[gi]),
        .empty(empty_vec[gi]),
        .head (head_data[gi]),
        .count(occupancy[gi])
      );

      // Unselected operands are driven as zero so the ALU sees a clean value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg[gi] <= '0;
        end else if (fire) begin
          data_reg[gi] <= mask[gi] ? head_data[gi] : '0;
        end
      end
    end
  endgenerate

  assign data_in1 = data_reg[0];
  assign data_in2 = data_reg[1];
  assign data_in3 = data_reg[2];

  // Occupancy is only observed for debug; fold it so it is not left dangling.
  assign unused_occupancy = ^{occupancy[0], occupancy[1], occupancy[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= OUT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OUT_EMPTY: if (fire) state_next = OUT_FULL;
      OUT_FULL:  if (op_ready && !fire) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_cnt_reg <= '0;
    end else if (fire) begin
      fire_cnt_reg <= fire_cnt_reg + FIRE_CNT_W'(1);
    end
  end

  assign fire_cnt = fire_cnt_reg;

endmodule

// File: tb/tb_pe_operand_join.sv
// tb_pe_operand_join: randomized and directed stimulus for pe_operand_join,
// checked every cycle against a queue-based transaction model.
module tb_pe_operand_join;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    mask;
  logic [DW-1:0] in1_data, in2_data, in3_data;
  logic          in1_valid, in2_valid, in3_valid;
  logic          in1_ready, in2_ready, in3_ready;
  logic [DW-1:0] data_in1, data_in2, data_in3;
  logic          op_valid;
  logic          op_ready;
  logic [15:0]   fire_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per operand, plus the output bundle.
  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];
  logic [DW-1:0] mq2[$];
  bit            m_valid;
  logic [DW-1:0] m_data [3];
  logic [15:0]   m_cnt;

  always #5 clk = ~clk;

  pe_operand_join #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_op_mask(mask),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in2_data   (in2_data),
    .in2_valid  (in2_valid),
    .in2_ready  (in2_ready),
    .in3_data   (in3_data),
    .in3_valid  (in3_valid),
    .in3_ready  (in3_ready),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_in3   (data_in3),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .fire_cnt   (fire_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return mq0.size();
      1:       return mq1.size();
      default: return mq2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qhead(input int i);
    case (i)
      0:       return mq0[0];
      1:       return mq1[0];
      default: return mq2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0:       void'(mq0.pop_front());
      1:       void'(mq1.pop_front());
      default: void'(mq2.pop_front());
    endcase
  endtask

  task automatic qpush(input int i, input logic [DW-1:0] d);
    case (i)
      0:       mq0.push_back(d);
      1:       mq1.push_back(d);
      default: mq2.push_back(d);
    endcase
  endtask

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    mq2.delete();
    m_valid = 0;
    m_cnt   = 16'h0;
    for (int i = 0; i < 3; i++) m_data[i] = '0;
  endtask

  // One clock cycle: drive inputs (called just after a rising edge), check
  // readies mid-cycle, advance the model at the edge, check outputs after it.
  task automatic step(input logic [2:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [DW-1:0] d2, input logic ordy, input bit chk);
    logic [2:0]    exp_rdy;
    logic [DW-1:0] dv [3];
    bit            all_have;
    bit            fire;
    dv[0] = d0;
    dv[1] = d1;
    dv[2] = d2;
    in1_valid = v[0]; in2_valid = v[1]; in3_valid = v[2];
    in1_data  = d0;   in2_data  = d1;   in3_data  = d2;
    op_ready  = ordy;
    all_have  = 1;
    for (int i = 0; i < 3; i++) begin
      exp_rdy[i] = mask[i] && (qsize(i) < DEPTH);
      if (mask[i] && qsize(i) == 0) all_have = 0;
    end
    fire = (mask != 3'b000) && all_have && (!m_valid || ordy);
    @(negedge clk);
    if (chk) check_eq("in_ready", {29'd0, in3_ready, in2_ready, in1_ready}, {29'd0, exp_rdy});
    @(posedge clk);
    if (fire) begin
      for (int i = 0; i < 3; i++) begin
        m_data[i] = mask[i] ? qhead(i) : '0;
        if (mask[i]) qpop(i);
      end
      m_valid = 1;
      m_cnt   = m_cnt + 16'd1;
      if (chk) $display("bundle #%0d: %h %h %h", m_cnt, m_data[0], m_data[1], m_data[2]);
    end else if (ordy) begin
      m_valid = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (v[i] && exp_rdy[i]) qpush(i, dv[i]);
    end
    #1;
    if (chk) begin
      check_eq("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
      check_eq("data_in1", data_in1, m_data[0]);
      check_eq("data_in2", data_in2, m_data[1]);
      check_eq("data_in3", data_in3, m_data[2]);
      check_eq("fire_cnt", {16'd0, fire_cnt}, {16'd0, m_cnt});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b000, '0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {29'd0, in3_ready, in2_ready, in1_ready}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, op_valid}, 32'd0);
    check_eq({tag, "_cnt"}, {16'd0, fire_cnt}, 32'd0);
    check_eq({tag, "_d1"}, data_in1, 32'd0);
    check_eq({tag, "_d2"}, data_in2, 32'd0);
    check_eq({tag, "_d3"}, data_in3, 32'd0);
  endtask

  logic [2:0] rand_masks [4];
  logic [15:0] cnt_start;

  initial begin
    rand_masks[0] = 3'b111; rand_masks[1] = 3'b101;
    rand_masks[2] = 3'b010; rand_masks[3] = 3'b110;
    rst_n = 1'b0;
    mask  = 3'b111;
    in1_valid = 0; in2_valid = 0; in3_valid = 0;
    in1_data = '0; in2_data = '0; in3_data = '0;
    op_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic join.
    step(3'b111, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1);
    step(3'b000, '0, '0, '0, 1'b1, 1'b1);
    check_eq("join_cnt", {16'd0, fire_cnt}, 32'd1);
    idle(3);

    // Skewed arrival with a partial mask; operand 3 must stay not-ready.
    mask = 3'b011;
    step(3'b001, 32'hA, '0, '0, 1'b1, 1'b1);
    step(3'b000, '0, '0, '0, 1'b1, 1'b1);
    step(3'b000, '0, '0, '0, 1'b1, 1'b1);
    step(3'b110, '0, 32'hB, 32'hC, 1'b1, 1'b1);
    step(3'b000, '0, '0, '0, 1'b1, 1'b1);
    check_eq("skew_d3", data_in3, 32'd0);
    idle(3);

    // Backpressure: stream with op_ready low until every FIFO is full, then drain.
    mask = 3'b111;
    for (int k = 0; k < 6; k++)
      step(3'b111, 32'h100 + k, 32'h200 + k, 32'h300 + k, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++)
      step(3'b000, '0, '0, '0, 1'b1, 1'b1);

    // Throughput: ten back-to-back bundles on operand 1 alone.
    mask = 3'b001;
    cnt_start = fire_cnt;
    for (int k = 0; k < 10; k++)
      step(3'b001, 32'h1000 + k, '0, '0, 1'b1, 1'b1);
    idle(3);
    check_eq("tput_cnt", {16'd0, fire_cnt}, {16'd0, cnt_start + 16'd10});

    // Randomized traffic over several masks.
    for (int m = 0; m < 4; m++) begin
      mask = rand_masks[m];
      for (int k = 0; k < 300; k++)
        step(3'($urandom), $urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0), 1'b1);
      idle(6);
    end

    // Reset mid-stream with full FIFOs.
    mask = 3'b111;
    for (int k = 0; k < 4; k++)
      step(3'b111, $urandom, $urandom, $urandom, 1'b0, 1'b1);
    in1_valid = 0; in2_valid = 0; in3_valid = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check_eq("post_rst_cnt", {16'd0, fire_cnt}, 32'd0);
    idle(2);

    // Counter wrap: stream on operand 1 until 0xFFFF bundles, then one more.
    mask = 3'b001;
    while (m_cnt != 16'hFFFF)
      step(3'b001, $urandom, '0, '0, 1'b1, 1'b0);
    step(3'b001, $urandom, '0, '0, 1'b1, 1'b1);
    check_eq("wrap_cnt", {16'd0, fire_cnt}, 32'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
